// File: rtl/mac_accumulator_pkg.sv
// Shared state encoding and default widths for the multiply-accumulate block.
package mac_accumulator_pkg;
  localparam int DEF_W     = 16;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } mac_state_t;
endpackage

// File: rtl/mac_accumulator_mult.sv
// Combinational unsigned multiplier; keeps only the low W bits of the product.
module mac_accumulator_mult #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_p
);
  // W-bit self-determined multiply drops the upper half of the full product
  assign o_p = i_a * i_b;
endmodule

// File: rtl/mac_accumulator.sv
// Streaming multiply-accumulate: sums a*b over a packet of beats ended by in_last,
// then holds the sum, term count and sticky carry flag until the consumer takes it.
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);
  mac_state_t       r_state;
  mac_state_t       w_state_nxt;
  logic [W-1:0]     r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [W-1:0]     w_prod;
  logic [W:0]       w_sum;
  logic             w_accept;
  logic             w_drain;

  mac_accumulator_mult #(.W(W)) u_mult (
    .i_a (in_a),
    .i_b (in_b),
    .o_p (w_prod)
  );

  assign w_sum    = {1'b0, r_acc} + {1'b0, w_prod};
  assign in_ready = (r_state != S_DONE);
  assign w_accept = in_valid && in_ready;
  assign w_drain  = (r_state == S_DONE) && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: if (w_accept) w_state_nxt = in_last ? S_DONE : S_ACCUM;
      S_DONE:          if (out_ready) w_state_nxt = S_IDLE;
      default:         w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_drain) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_accept) begin
        r_acc <= w_sum[W-1:0];
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
        if (w_sum[W]) r_ovf <= 1'b1;
      end
    end
  end

  assign out_valid    = (r_state == S_DONE);
  assign out_sum      = r_acc;
  assign out_count    = r_cnt;
  assign out_overflow = r_ovf;
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: table of beats with hand-computed sums,
// plus sequences for backpressure, drain-cycle blocking, reset and count saturation.
module tb_mac_accumulator;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  logic        out_overflow;

  int checks = 0;
  int errors = 0;

  mac_accumulator #(.W(16), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
    logic [15:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_a     = 16'hDEAD;
    in_b     = 16'hBEEF;
    in_last  = 1'b1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_out_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{16'd3,     16'd4,     1'b0, 16'd0,     8'd0, 1'b0};
    vecs[1] = '{16'd5,     16'd6,     1'b0, 16'd0,     8'd0, 1'b0};
    vecs[2] = '{16'd7,     16'd8,     1'b1, 16'd98,    8'd3, 1'b0};
    vecs[3] = '{16'd300,   16'd300,   1'b1, 16'd24464, 8'd1, 1'b0};
    vecs[4] = '{16'hFFFF,  16'd1,     1'b0, 16'd0,     8'd0, 1'b0};
    vecs[5] = '{16'd2,     16'd1,     1'b1, 16'd1,     8'd2, 1'b1};
    vecs[6] = '{16'd1,     16'd1,     1'b1, 16'd1,     8'd1, 1'b0};
    vecs[7] = '{16'h0100,  16'h0100,  1'b1, 16'd0,     8'd1, 1'b0};
    vecs[8] = '{16'h8000,  16'd2,     1'b0, 16'd0,     8'd0, 1'b0};
    vecs[9] = '{16'hFFFF,  16'hFFFF,  1'b1, 16'd1,     8'd2, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_sum", {16'b0, out_sum}, 32'd0);
    chk("rst_out_count", {24'b0, out_count}, 32'd0);
    chk("rst_out_overflow", {31'b0, out_overflow}, 32'd0);

    // table: sums built from back-to-back beats
    for (int i = 0; i < 10; i++) begin
      beat(vecs[i].a, vecs[i].b, vecs[i].last);
      chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].last});
      if (vecs[i].last) begin
        chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
        chk($sformatf("v%0d_sum", i), {16'b0, out_sum}, {16'b0, vecs[i].sum});
        chk($sformatf("v%0d_count", i), {24'b0, out_count}, {24'b0, vecs[i].cnt});
        chk($sformatf("v%0d_ovf", i), {31'b0, out_overflow}, {31'b0, vecs[i].ovf});
        drain();
        chk($sformatf("v%0d_cleared", i), {out_overflow, out_count, out_sum}, 32'd0);
      end
    end

    // backpressure: held output, no input accepted while DONE
    beat(16'd2, 16'd3, 1'b1);
    in_valid = 1'b1; in_a = 16'd9; in_b = 16'd9; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_sum", {16'b0, out_sum}, 32'd6);
      chk("bp_count", {24'b0, out_count}, 32'd1);
      tick();
    end
    // drain cycle with in_valid still high: beat must not be taken on that edge
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_out_valid", {31'b0, out_valid}, 32'd0);
    chk("hs_in_ready", {31'b0, in_ready}, 32'd1);
    chk("hs_no_accept_count", {24'b0, out_count}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("resume_out_valid", {31'b0, out_valid}, 32'd1);
    chk("resume_sum", {16'b0, out_sum}, 32'd81);
    chk("resume_count", {24'b0, out_count}, 32'd1);
    drain();

    // reset in ACCUM discards partial sum
    beat(16'd2, 16'd2, 1'b0);
    beat(16'd3, 16'd3, 1'b0);
    chk("pre_rst_sum", {16'b0, out_sum}, 32'd13);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out", {out_overflow, out_count, out_sum}, 32'd0);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    beat(16'd1, 16'd5, 1'b1);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("post_rst_sum", {16'b0, out_sum}, 32'd5);
    chk("post_rst_count", {24'b0, out_count}, 32'd1);

    // reset in DONE overrides a simultaneous handshake and drops the sum
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    chk("done_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("done_rst_out", {out_overflow, out_count, out_sum}, 32'd0);

    // count saturation
    for (int i = 0; i < 300; i++) beat(16'd0, 16'd0, 1'b0);
    chk("sat_pre_last_count", {24'b0, out_count}, 32'd255);
    beat(16'd0, 16'd0, 1'b1);
    chk("sat_out_valid", {31'b0, out_valid}, 32'd1);
    chk("sat_count", {24'b0, out_count}, 32'd255);
    chk("sat_sum", {16'b0, out_sum}, 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning operand, product and accumulator width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning width of the term counter.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port in_valid  input  1  an operand pair is presented.
REQ-006 Port in_ready  output  1  the block accepts an operand pair this cycle.
REQ-007 Port in_a  input  W  multiplicand, unsigned.
REQ-008 Port in_b  input  W  multiplier, unsigned.
REQ-009 Port in_last  input  1  the presented pair is the final term of the current sum.
REQ-010 Port out_valid  output  1  a finished sum is presented.
REQ-011 Port out_ready  input  1  the consumer takes the sum this cycle.
REQ-012 Port out_sum  output  W  accumulated sum of products, modulo 2^W.
REQ-013 Port out_count  output  CNT_W  number of terms in the sum, saturating.
REQ-014 Port out_overflow  output  1  a carry out of bit W-1 occurred in at least one accumulation of this sum.

Function
REQ-015 An input beat SHALL be accepted exactly when in_valid and in_ready are both 1 at a rising clk edge.
REQ-016 The FSM SHALL have states IDLE (no terms yet), ACCUM (at least one term accepted, no last yet) and DONE (sum held on the output).
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-018 The product SHALL be the low W bits of in_a*in_b, computed combinationally through the multiplier sub-module.
REQ-019 On an accepted beat, acc SHALL become (acc + product) mod 2^W on the same edge, giving zero added latency per term.
REQ-020 On an accepted beat, the term count SHALL increment by 1 and saturate at 2^CNT_W-1 without wrapping.
REQ-021 The overflow flag SHALL become sticky-1 on any accepted beat where acc + product is at least 2^W.
REQ-022 An accepted beat with in_last=0 SHALL move IDLE or ACCUM to ACCUM.
REQ-023 An accepted beat with in_last=1 SHALL move IDLE or ACCUM to DONE, and out_valid SHALL be 1 in the cycle after that beat.
REQ-024 A single-beat sum, where the first beat has in_last=1, SHALL be legal and SHALL yield out_count=1.
REQ-025 In DONE, out_sum, out_count and out_overflow SHALL be held stable and out_valid SHALL stay 1 until out_ready=1.
REQ-026 A DONE cycle with out_ready=1 SHALL complete the output handshake and then clear acc, count and the overflow flag and go to IDLE.
REQ-027 No input beat SHALL be accepted in the cycle where DONE completes its output handshake; input acceptance resumes the following cycle.
REQ-028 out_valid SHALL be 0 in IDLE and ACCUM.
REQ-029 out_sum, out_count and out_overflow SHALL show the live accumulator values in IDLE and ACCUM; these values are not meaningful to the consumer.
REQ-030 in_a, in_b and in_last SHALL be ignored when in_valid=0.

Reset
REQ-031 When rst=1 at a clk edge, the block SHALL enter IDLE with acc=0, count=0 and overflow=0.
REQ-032 Reset values SHALL be out_valid=0, out_sum=0, out_count=0 and out_overflow=0, with in_ready=1 from the first cycle after reset.
REQ-033 rst SHALL take priority over any handshake in the same cycle.
REQ-034 A reset during ACCUM or DONE SHALL discard the partial or pending sum without emitting it.

Structure
REQ-035 State encoding constants (IDLE, ACCUM, DONE) and the default widths W=16 and CNT_W=8 SHALL live in a shared package.
REQ-036 The block SHALL instantiate the existing multiplier module with parameter W as its only sub-module.
REQ-037 All registers SHALL be in one clocked process, and the next-state, in_ready and product logic SHALL be combinational.

Verification
REQ-038 Basic sum: beats (3,4), (5,6), (7,8,last) back-to-back with out_ready=1 -> out_valid one cycle after the last beat, with out_sum=98, out_count=3 and out_overflow=0.
REQ-039 Product truncation: single beat (300,300,last) -> out_sum=24464 (90000 mod 65536), out_count=1 and out_overflow=0.
REQ-040 Accumulator wrap: beats (0xFFFF,1), (2,1,last) -> out_sum=1 and out_overflow=1; the next sum, (1,1,last), gives out_overflow=0.
REQ-041 Backpressure: hold out_ready=0 for 5 cycles after the sum becomes valid -> out_valid and out_sum stay stable and in_ready=0 throughout; after out_ready=1 the block returns to IDLE with in_ready=1 the next cycle.
REQ-042 Reset mid-operation: assert rst after beats (2,2), (3,3) and before the last beat -> all outputs return to their reset values; the following sum (1,5,last) gives out_sum=5 and out_count=1.
REQ-043 Count saturation: 300 beats of (0,0) then last -> out_count=255 and out_sum=0.
